ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Parametrised successor to the single-signal opcode decoder.
- Decodes the full MIPS-lite control bundle from instr_d in the D stage, then carries it through registered E, M and W stages.
- Supports stall/flush bubble insertion and counts illegal instructions.
- Sits beside the datapath stage registers; the datapath reads its per-stage control outputs.

Parameters:
OP_W, 6, opcode field width (instr[31:26])
FUNCT_W, 6, funct field width (instr[5:0])
ALUOP_W, 3, width of alu_op bundles (min 2)
CNT_W, 8, width of saturating illegal-instruction counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset (0 = reset)
instr_d  in  32  instruction in D stage
valid_d  in  1  instr_d holds a real instruction
stall  in  1  hazard stall: insert bubble into E
flush  in  1  control flush: insert bubble into E
ext_op_d  out  1  D: 1 sign-extend, 0 zero-extend (combinational)
npc_op_d  out  2  D: 0 pc+4, 1 beq, 2 j/jal, 3 jr (combinational)
illegal_d  out  1  D: valid_d & undecodable (combinational)
alu_src_e  out  1  E: ALU B from immediate
alu_op_e  out  ALUOP_W  E: 0 add, 1 sub, 2 or, 3 lui
reg_dst_e  out  2  E: 0 rt, 1 rd, 2 $31
valid_e  out  1  E stage valid
mem_write_m  out  1  M: store enable
valid_m  out  1  M stage valid
reg_write_w  out  1  W: GRF write enable
wb_sel_w  out  2  W: 0 ALU, 1 memory, 2 pc+8
valid_w  out  1  W stage valid
illegal_cnt  out  CNT_W  saturating count of illegal instructions entering E

Behaviour:
- Decode table, by opcode:
  - 000000 R-type, by funct:
    - 100001 addu: reg_dst 1, alu_op 0, reg_write 1.
    - 100011 subu: reg_dst 1, alu_op 1, reg_write 1.
    - 000000 sll: treated as nop, all zero.
    - 001000 jr: npc 3.
  - 001101 ori: alu_src 1, alu_op 2, ext 0, reg_write 1.
  - 100011 lw: alu_src 1, alu_op 0, ext 1, wb_sel 1, reg_write 1.
  - 101011 sw: alu_src 1, alu_op 0, ext 1, mem_write 1.
  - 001111 lui: alu_src 1, alu_op 3, reg_write 1.
  - 000100 beq: alu_op 1, ext 1, npc 1.
  - 000010 j: npc 2.
  - 000011 jal: npc 2, reg_dst 2, wb_sel 2, reg_write 1.
  - Any other opcode/funct: illegal; bundle all zero.
- Unlisted bundle fields are 0. alu_op values are zero-extended to ALUOP_W.
- D-stage outputs:
  - Pure combinational from instr_d.
  - Forced to 0 when valid_d=0, except illegal_d, which is also 0 then.
- Bubble: all control fields 0 and valid 0. A bubble never writes GRF or memory.
- Each rising clk, E is loaded with:
  - the decoded bundle, and valid_e = 1, if valid_d & ~illegal_d & ~stall & ~flush;
  - otherwise a bubble.
- stall and flush asserted together: a single bubble. Behaviour is identical to either alone.
- Illegal instruction: becomes a bubble in E, and illegal_cnt increments when valid_d & illegal_d & ~stall & ~flush.
- illegal_cnt saturates at 2^CNT_W-1 and never wraps.
- M and W always advance, regardless of stall/flush. Write enables are gated by the source stage valid.
- Latency: E = 1 cycle after D, M = 2 cycles, W = 3 cycles.
- Reset (reset=0, asynchronous):
  - All E/M/W registers and illegal_cnt go to 0 immediately, even mid-pipeline.
  - Outputs hold 0 while reset=0.
  - The first capture is on the first rising clk after reset deasserts.
- Field extraction: op = instr_d[31:26], funct = instr_d[5:0]. Widths are fixed by OP_W/FUNCT_W. Other bits are ignored.

Test Plan:
1. Reset mid-stream:
   - Stimulus: issue lw then sw; pull reset low between clk edges.
   - Required: all E/M/W outputs and illegal_cnt read 0 without waiting for a clock edge.
   - Required after release: the first clock captures instr_d normally.
2. Decode sweep:
   - Stimulus: feed ori 0x3421_0005, lw 0x8C22_0004, sw 0xAC22_0004, lui 0x3C01_1234, addu 0x0022_1821, subu 0x0022_1823 back-to-back.
   - Required on E: alu_src_e = 1,1,1,1,0,0.
   - Required on E: alu_op_e = 2,0,0,3,0,1.
   - Required on W, three cycles after D: reg_write_w = 1,1,0,1,1,1.
3. Stall:
   - Stimulus: lw in D with stall=1 for 2 cycles, then stall=0.
   - Required: E shows 2 bubbles (valid_e=0, alu_src_e=0), then the lw bundle.
   - Required: mem_write_m never asserted by the bubbles.
4. Simultaneous stall+flush on sw:
   - Required: exactly one bubble; mem_write_m=0 two cycles later.
   - Required: illegal_cnt unchanged.
5. Illegal and saturation:
   - Stimulus: op 0x3F with valid_d=1 → illegal_d=1, E bubble, illegal_cnt +1.
   - Stimulus: repeat 300 cycles with CNT_W=8 → illegal_cnt stops at 255.
   - Stimulus: same op with valid_d=0 → no increment.
6. jal/jr:
   - Stimulus: jal 0x0C00_0010 in D → npc_op_d=2, reg_dst_e=2 next cycle, wb_sel_w=2 with reg_write_w=1 at W.
   - Stimulus: jr 0x03E0_0008 in D → npc_op_d=3, reg_write_w=0.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: groups the D-stage instruction inputs and the per-stage
// control outputs of ctrl_pipe.
//   master : drives instr_d/valid_d/stall/flush and observes the controls
//   slave  : the control pipeline itself
interface ctrl_pipe_if #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 8
);
    logic [31:0]        instr_d;
    logic               valid_d;
    logic               stall;
    logic               flush;
    logic               ext_op_d;
    logic [1:0]         npc_op_d;
    logic               illegal_d;
    logic               alu_src_e;
    logic [ALUOP_W-1:0] alu_op_e;
    logic [1:0]         reg_dst_e;
    logic               valid_e;
    logic               mem_write_m;
    logic               valid_m;
    logic               reg_write_w;
    logic [1:0]         wb_sel_w;
    logic               valid_w;
    logic [CNT_W-1:0]   illegal_cnt;

    modport master (
        output instr_d, valid_d, stall, flush,
        input  ext_op_d, npc_op_d, illegal_d,
        input  alu_src_e, alu_op_e, reg_dst_e, valid_e,
        input  mem_write_m, valid_m,
        input  reg_write_w, wb_sel_w, valid_w,
        input  illegal_cnt
    );

    modport slave (
        input  instr_d, valid_d, stall, flush,
        output ext_op_d, npc_op_d, illegal_d,
        output alu_src_e, alu_op_e, reg_dst_e, valid_e,
        output mem_write_m, valid_m,
        output reg_write_w, wb_sel_w, valid_w,
        output illegal_cnt
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: MIPS-lite control decoder plus E/M/W control pipeline.
// Decodes instr_d combinationally in D (ext_op_d, npc_op_d, illegal_d),
// then registers the control bundle through E, M and W. stall/flush or an
// illegal instruction load a bubble into E; M and W always advance.
// illegal_cnt is a saturating count of illegal instructions that would
// have entered E.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - ctrl_pipe_if.slave: instr_d/valid_d/stall/flush in, per-stage
//           control outputs and illegal_cnt out
module ctrl_pipe #(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    ctrl_pipe_if.slave bus
);
    localparam logic [OP_W-1:0]    OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0]    OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0]    OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0]    OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0]    OP_LUI   = OP_W'(6'b001111);
    localparam logic [OP_W-1:0]    OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0]    OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0]    OP_JAL   = OP_W'(6'b000011);
    localparam logic [FUNCT_W-1:0] FN_ADDU  = FUNCT_W'(6'b100001);
    localparam logic [FUNCT_W-1:0] FN_SUBU  = FUNCT_W'(6'b100011);
    localparam logic [FUNCT_W-1:0] FN_SLL   = FUNCT_W'(6'b000000);
    localparam logic [FUNCT_W-1:0] FN_JR    = FUNCT_W'(6'b001000);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(3);

    // Fields consumed in E and beyond; M and W carry shrinking subsets.
    typedef struct packed {
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         reg_dst;
        logic               mem_write;
        logic               reg_write;
        logic [1:0]         wb_sel;
    } ctl_e_t;

    typedef struct packed {
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
    } ctl_m_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wb_sel;
    } ctl_w_t;

    typedef struct packed {
        ctl_e_t     e;
        logic       ext;
        logic [1:0] npc;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode(input logic [OP_W-1:0] op,
                                    input logic [FUNCT_W-1:0] funct);
        dec_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin
                        c.e.reg_dst = 2'd1; c.e.alu_op = ALU_ADD; c.e.reg_write = 1'b1;
                    end
                    FN_SUBU: begin
                        c.e.reg_dst = 2'd1; c.e.alu_op = ALU_SUB; c.e.reg_write = 1'b1;
                    end
                    FN_SLL:  ;  // nop: legal, empty bundle
                    FN_JR:   c.npc = 2'd3;
                    default: c.illegal = 1'b1;
                endcase
            end
            OP_ORI: begin
                c.e.alu_src = 1'b1; c.e.alu_op = ALU_OR; c.e.reg_write = 1'b1;
            end
            OP_LW: begin
                c.e.alu_src = 1'b1; c.e.alu_op = ALU_ADD; c.ext = 1'b1;
                c.e.wb_sel = 2'd1; c.e.reg_write = 1'b1;
            end
            OP_SW: begin
                c.e.alu_src = 1'b1; c.e.alu_op = ALU_ADD; c.ext = 1'b1;
                c.e.mem_write = 1'b1;
            end
            OP_LUI: begin
                c.e.alu_src = 1'b1; c.e.alu_op = ALU_LUI; c.e.reg_write = 1'b1;
            end
            OP_BEQ: begin
                c.e.alu_op = ALU_SUB; c.ext = 1'b1; c.npc = 2'd1;
            end
            OP_J:   c.npc = 2'd2;
            OP_JAL: begin
                c.npc = 2'd2; c.e.reg_dst = 2'd2; c.e.wb_sel = 2'd2;
                c.e.reg_write = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [OP_W-1:0]    op_p0;
    logic [FUNCT_W-1:0] funct_p0;
    logic               unused_instr_bits;
    dec_t               dec_p0;
    logic               clean_p0;
    logic               take_p0;
    logic               count_p0;

    ctl_e_t           ctl_p1_d, ctl_p1_q;
    logic             vld_p1_d, vld_p1_q;
    ctl_m_t           ctl_p2_d, ctl_p2_q;
    logic             vld_p2_d, vld_p2_q;
    ctl_w_t           ctl_p3_d, ctl_p3_q;
    logic             vld_p3_d, vld_p3_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // ---- D stage: combinational decode ----
    assign op_p0    = bus.instr_d[31 -: OP_W];
    assign funct_p0 = bus.instr_d[FUNCT_W-1:0];
    // Register/immediate fields between opcode and funct belong to the datapath.
    assign unused_instr_bits = ^bus.instr_d[31-OP_W:FUNCT_W];

    assign dec_p0   = decode(op_p0, funct_p0);
    assign clean_p0 = bus.valid_d & ~bus.stall & ~bus.flush;
    assign take_p0  = clean_p0 & ~dec_p0.illegal;
    assign count_p0 = clean_p0 &  dec_p0.illegal;

    assign bus.ext_op_d  = bus.valid_d & dec_p0.ext;
    assign bus.npc_op_d  = bus.valid_d ? dec_p0.npc : 2'd0;
    assign bus.illegal_d = bus.valid_d & dec_p0.illegal;

    always_comb begin
        ctl_p1_d = '0;
        vld_p1_d = 1'b0;
        if (take_p0) begin
            ctl_p1_d = dec_p0.e;
            vld_p1_d = 1'b1;
        end
        ctl_p2_d.mem_write = ctl_p1_q.mem_write & vld_p1_q;
        ctl_p2_d.reg_write = ctl_p1_q.reg_write & vld_p1_q;
        ctl_p2_d.wb_sel    = ctl_p1_q.wb_sel;
        vld_p2_d           = vld_p1_q;
        ctl_p3_d.reg_write = ctl_p2_q.reg_write & vld_p2_q;
        ctl_p3_d.wb_sel    = ctl_p2_q.wb_sel;
        vld_p3_d           = vld_p2_q;
        cnt_d = count_p0 ? sat_inc(cnt_q) : cnt_q;
    end

    // ---- D -> E -> M -> W registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_p1_q <= '0;
            vld_p1_q <= 1'b0;
            ctl_p2_q <= '0;
            vld_p2_q <= 1'b0;
            ctl_p3_q <= '0;
            vld_p3_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ctl_p1_q <= ctl_p1_d;
            vld_p1_q <= vld_p1_d;
            ctl_p2_q <= ctl_p2_d;
            vld_p2_q <= vld_p2_d;
            ctl_p3_q <= ctl_p3_d;
            vld_p3_q <= vld_p3_d;
            cnt_q    <= cnt_d;
        end
    end

    // ---- E stage outputs ----
    assign bus.alu_src_e = ctl_p1_q.alu_src;
    assign bus.alu_op_e  = ctl_p1_q.alu_op;
    assign bus.reg_dst_e = ctl_p1_q.reg_dst;
    assign bus.valid_e   = vld_p1_q;

    // ---- M stage outputs ----
    assign bus.mem_write_m = ctl_p2_q.mem_write & vld_p2_q;
    assign bus.valid_m     = vld_p2_q;

    // ---- W stage outputs ----
    assign bus.reg_write_w = ctl_p3_q.reg_write & vld_p3_q;
    assign bus.wb_sel_w    = ctl_p3_q.wb_sel;
    assign bus.valid_w     = vld_p3_q;

    assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: randomized and directed stimulus for ctrl_pipe, checked
// against an instruction-level reference model (decode by mnemonic, a
// three-entry stage history and a saturating illegal counter).
module tb_ctrl_pipe;
    localparam int ALUOP_W = 3;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [31:0] I_ORI  = 32'h3421_0005;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_LUI  = 32'h3C01_1234;
    localparam logic [31:0] I_ADDU = 32'h0022_1821;
    localparam logic [31:0] I_SUBU = 32'h0022_1823;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    logic clk;
    logic reset;

    ctrl_pipe_if #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

    ctrl_pipe #(
        .OP_W(6), .FUNCT_W(6), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int alu_src, alu_op, reg_dst, ext, npc, mem_write, reg_write, wb_sel, illegal;
    } dec_t;

    typedef struct {
        int valid, alu_src, alu_op, reg_dst, mem_write, reg_write, wb_sel;
    } stage_t;

    int     n_checks = 0;
    int     n_errors = 0;
    stage_t m_e, m_m, m_w;
    int     m_cnt;
    int     seen_npc;

    int exp_src[6] = '{1, 1, 1, 1, 0, 0};
    int exp_op[6]  = '{2, 0, 0, 3, 0, 1};
    int exp_rw[6]  = '{1, 1, 0, 1, 1, 1};
    logic [31:0] sweep[6];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode written from the instruction table by mnemonic.
    function automatic dec_t model_decode(input logic [31:0] ins);
        dec_t r;
        logic [5:0] op, fn;
        r = '{default: 0};
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00 && fn == 6'h21) begin        // addu
            r.reg_dst = 1; r.reg_write = 1;
        end else if (op == 6'h00 && fn == 6'h23) begin // subu
            r.reg_dst = 1; r.alu_op = 1; r.reg_write = 1;
        end else if (op == 6'h00 && fn == 6'h00) begin // sll / nop
        end else if (op == 6'h00 && fn == 6'h08) begin // jr
            r.npc = 3;
        end else if (op == 6'h0D) begin               // ori
            r.alu_src = 1; r.alu_op = 2; r.reg_write = 1;
        end else if (op == 6'h23) begin               // lw
            r.alu_src = 1; r.ext = 1; r.wb_sel = 1; r.reg_write = 1;
        end else if (op == 6'h2B) begin               // sw
            r.alu_src = 1; r.ext = 1; r.mem_write = 1;
        end else if (op == 6'h0F) begin               // lui
            r.alu_src = 1; r.alu_op = 3; r.reg_write = 1;
        end else if (op == 6'h04) begin               // beq
            r.alu_op = 1; r.ext = 1; r.npc = 1;
        end else if (op == 6'h02) begin               // j
            r.npc = 2;
        end else if (op == 6'h03) begin               // jal
            r.npc = 2; r.reg_dst = 2; r.wb_sel = 2; r.reg_write = 1;
        end else begin
            r.illegal = 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 12))
            0:  begin r[31:26] = 6'h00; r[5:0] = 6'h21; end
            1:  begin r[31:26] = 6'h00; r[5:0] = 6'h23; end
            2:  begin r[31:26] = 6'h00; r[5:0] = 6'h00; end
            3:  begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
            4:  r[31:26] = 6'h0D;
            5:  r[31:26] = 6'h23;
            6:  r[31:26] = 6'h2B;
            7:  r[31:26] = 6'h0F;
            8:  r[31:26] = 6'h04;
            9:  r[31:26] = 6'h02;
            10: r[31:26] = 6'h03;
            11: r[31:26] = 6'h00;   // R-type with random funct
            default: ;              // fully random word
        endcase
        return r;
    endfunction

    task automatic model_clear();
        m_e = '{default: 0};
        m_m = '{default: 0};
        m_w = '{default: 0};
        m_cnt = 0;
    endtask

    task automatic check_pipe();
        chk("valid_e",     bus.valid_e,     m_e.valid);
        chk("alu_src_e",   bus.alu_src_e,   m_e.alu_src);
        chk("alu_op_e",    bus.alu_op_e,    m_e.alu_op);
        chk("reg_dst_e",   bus.reg_dst_e,   m_e.reg_dst);
        chk("valid_m",     bus.valid_m,     m_m.valid);
        chk("mem_write_m", bus.mem_write_m, m_m.valid ? m_m.mem_write : 0);
        chk("valid_w",     bus.valid_w,     m_w.valid);
        chk("reg_write_w", bus.reg_write_w, m_w.valid ? m_w.reg_write : 0);
        chk("wb_sel_w",    bus.wb_sel_w,    m_w.wb_sel);
        chk("illegal_cnt", bus.illegal_cnt, m_cnt);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid_e"},     bus.valid_e,     0);
        chk({tag, "_alu_src_e"},   bus.alu_src_e,   0);
        chk({tag, "_alu_op_e"},    bus.alu_op_e,    0);
        chk({tag, "_reg_dst_e"},   bus.reg_dst_e,   0);
        chk({tag, "_valid_m"},     bus.valid_m,     0);
        chk({tag, "_mem_write_m"}, bus.mem_write_m, 0);
        chk({tag, "_valid_w"},     bus.valid_w,     0);
        chk({tag, "_reg_write_w"}, bus.reg_write_w, 0);
        chk({tag, "_wb_sel_w"},    bus.wb_sel_w,    0);
        chk({tag, "_illegal_cnt"}, bus.illegal_cnt, 0);
    endtask

    // One D-stage slot: drive at negedge, check D outputs, clock, check E/M/W.
    task automatic cycle(input logic [31:0] ins, input bit v, input bit st, input bit fl);
        dec_t   d;
        stage_t nxt;
        @(negedge clk);
        bus.instr_d = ins;
        bus.valid_d = v;
        bus.stall   = st;
        bus.flush   = fl;
        #1;
        d = model_decode(ins);
        chk("ext_op_d",  bus.ext_op_d,  v ? d.ext : 0);
        chk("npc_op_d",  bus.npc_op_d,  v ? d.npc : 0);
        chk("illegal_d", bus.illegal_d, v ? d.illegal : 0);
        seen_npc = bus.npc_op_d;
        nxt = '{default: 0};
        if (v && d.illegal == 0 && !st && !fl) begin
            nxt.valid     = 1;
            nxt.alu_src   = d.alu_src;
            nxt.alu_op    = d.alu_op;
            nxt.reg_dst   = d.reg_dst;
            nxt.mem_write = d.mem_write;
            nxt.reg_write = d.reg_write;
            nxt.wb_sel    = d.wb_sel;
        end
        if (v && d.illegal != 0 && !st && !fl && m_cnt < CNT_MAX) m_cnt++;
        @(posedge clk);
        #1;
        m_w = m_m;
        m_m = m_e;
        m_e = nxt;
        check_pipe();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_before;
        sweep = '{I_ORI, I_LW, I_SW, I_LUI, I_ADDU, I_SUBU};
        reset       = 1'b0;
        bus.instr_d = '0;
        bus.valid_d = 1'b0;
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        model_clear();
        #1;
        check_zero("rst0");
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle(rand_instr(), $urandom_range(0, 99) < 85,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);

        // Decode sweep; W shows instruction i-2 after slot i
        for (int i = 0; i < 8; i++) begin
            if (i < 6) cycle(sweep[i], 1'b1, 1'b0, 1'b0);
            else       cycle($urandom, 1'b0, 1'b0, 1'b0);
            if (i < 6) begin
                chk("sweep_alu_src_e", bus.alu_src_e, exp_src[i]);
                chk("sweep_alu_op_e",  bus.alu_op_e,  exp_op[i]);
            end
            if (i >= 2) chk("sweep_reg_write_w", bus.reg_write_w, exp_rw[i-2]);
        end

        // Stall holds lw out of E for two slots
        for (int i = 0; i < 3; i++) begin
            cycle(I_LW, 1'b1, i < 2, 1'b0);
            chk("stall_valid_e",   bus.valid_e,   i < 2 ? 0 : 1);
            chk("stall_alu_src_e", bus.alu_src_e, i < 2 ? 0 : 1);
        end
        for (int i = 0; i < 3; i++) begin
            cycle($urandom, 1'b0, 1'b0, 1'b0);
            chk("stall_mem_write_m", bus.mem_write_m, 0);
        end

        // stall + flush on sw: one bubble, no store, counter untouched
        cnt_before = m_cnt;
        cycle(I_SW, 1'b1, 1'b1, 1'b1);
        chk("sf_valid_e", bus.valid_e, 0);
        cycle($urandom, 1'b0, 1'b0, 1'b0);
        chk("sf_mem_write_m", bus.mem_write_m, 0);
        cycle($urandom, 1'b0, 1'b0, 1'b0);
        chk("sf_valid_w", bus.valid_w, 0);
        cycle(I_BAD, 1'b1, 1'b1, 1'b0);
        chk("sf_cnt_stall_illegal", bus.illegal_cnt, cnt_before);

        // Illegal opcode
        cnt_before = bus.illegal_cnt;
        cycle(I_BAD, 1'b1, 1'b0, 1'b0);
        chk("ill_valid_e", bus.valid_e, 0);
        chk("ill_cnt_inc", bus.illegal_cnt, cnt_before + 1);
        cycle(I_BAD, 1'b0, 1'b0, 1'b0);
        chk("ill_cnt_novalid", bus.illegal_cnt, cnt_before + 1);

        // jal / jr
        cycle(I_JAL, 1'b1, 1'b0, 1'b0);
        chk("jal_npc_op_d", seen_npc, 2);
        chk("jal_reg_dst_e", bus.reg_dst_e, 2);
        cycle($urandom, 1'b0, 1'b0, 1'b0);
        cycle($urandom, 1'b0, 1'b0, 1'b0);
        chk("jal_wb_sel_w", bus.wb_sel_w, 2);
        chk("jal_reg_write_w", bus.reg_write_w, 1);
        cycle(I_JR, 1'b1, 1'b0, 1'b0);
        chk("jr_npc_op_d", seen_npc, 3);
        cycle($urandom, 1'b0, 1'b0, 1'b0);
        cycle($urandom, 1'b0, 1'b0, 1'b0);
        chk("jr_valid_w", bus.valid_w, 1);
        chk("jr_reg_write_w", bus.reg_write_w, 0);

        // Saturation
        for (int i = 0; i < 300; i++) cycle(I_BAD, 1'b1, 1'b0, 1'b0);
        chk("sat_cnt", bus.illegal_cnt, CNT_MAX);
        cycle(I_BAD, 1'b1, 1'b0, 1'b0);
        chk("sat_cnt_hold", bus.illegal_cnt, CNT_MAX);

        // Reset mid-stream: lw in M, sw in E, asserted between edges
        cycle(I_LW, 1'b1, 1'b0, 1'b0);
        cycle(I_SW, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_valid_m", bus.valid_m, 1);
        #2 reset = 1'b0;
        #1;
        check_zero("rst_async");
        model_clear();
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        #2 reset = 1'b1;
        cycle(I_LW, 1'b1, 1'b0, 1'b0);
        chk("post_rst_valid_e", bus.valid_e, 1);
        chk("post_rst_alu_src_e", bus.alu_src_e, 1);
        for (int i = 0; i < 3; i++) cycle($urandom, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
